// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states, width limits.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: hold at zero while cleared, wrap after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With one clock per bit the counter sits at zero and every cycle is a tick.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, one or two stop bits; OUT comes straight from a flop.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TX_EN,
    input  logic                 START,
    input  logic [DATA_BITS-1:0] TX_IN,
    output logic                 OUT,
    output logic                 BUSY,
    output logic                 DONE
);
    import uart_pkg::*;

    localparam int SW = DATA_BITS + 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..%0d", MAX_DATA_BITS);
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 1");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        return (PARITY == PAR_ODD) ? ~^w : ^w;
    endfunction

    tx_state_t         state_q, state_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              out_q, out_d;
    logic              done_q, done_d;
    logic              tick;

    // Baud counter is held clear in IDLE so each frame starts on a fresh bit time.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (CLK),
        .rst (RST),
        .clr (state_q == IDLE),
        .tick(tick)
    );

    // Next-state and next-output logic; OUT is prepared one cycle ahead of the line.
    // The parity bit rides above the data word, so it reaches bit 1 as the last data bit goes out.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        out_d      = out_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                out_d = 1'b1;
                if (START && TX_EN) begin
                    shift_d   = {parity_bit(TX_IN), TX_IN};
                    bit_cnt_d = '0;
                    state_d   = START_BIT;
                    out_d     = 1'b0;
                end
            end
            START_BIT: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    out_d     = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    out_d     = shift_q[1];
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = uart_pkg::PARITY;
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = 1'b0;
                            out_d      = 1'b1;
                        end
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    out_d      = 1'b1;
                end
            end
            STOP: begin
                out_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
            end
        endcase
    end

    // Control registers; reset truncates any frame in flight without a DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            out_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            out_q      <= out_d;
            done_q     <= done_d;
        end
    end

    // Data shift register; contents only matter once a word has been accepted.
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    assign OUT  = out_q;
    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, next generation of the fixed 8N1 one-clock-per-bit transmitter. Serialises a DATA_BITS-wide word onto OUT, LSB first, with a programmable clocks-per-bit divider, optional odd/even parity and one or two stop bits. Sits between the byte-producing logic and the serial pin. Keeps the same START/TX_EN request style and BUSY/DONE status style as the previous transmitter.

## Interface
- DATA_BITS, 8, data word width; legal 5..9
- CLKS_PER_BIT, 16, CLK cycles per serial bit; legal ≥1
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, number of stop bits; legal 1 or 2
- CLK  in  1  clock; the only clock
- RST  in  1  reset, synchronous, active-high
- TX_EN  in  1  transmitter enable; gates acceptance of START
- START  in  1  frame request; sampled only in IDLE
- TX_IN  in  DATA_BITS  word to send; captured on acceptance
- OUT  out  1  serial line; idle/mark = 1
- BUSY  out  1  high while a frame is on the line
- DONE  out  1  one-cycle pulse at end of frame

## Operation
- Reset values: OUT=1, BUSY=0, DONE=0, state IDLE, bit counter 0, baud counter 0.
- States: IDLE → START_BIT → DATA → PARITY (only if PARITY≠0) → STOP → IDLE.
- Acceptance: in IDLE, START & TX_EN at a rising edge latches TX_IN into a shift register, clears the baud counter and enters START_BIT.
- Baud counter runs 0..CLKS_PER_BIT-1. Each bit state holds OUT constant for exactly CLKS_PER_BIT cycles. The terminal count advances the bit or state.
- START_BIT: OUT=0.
- DATA: OUT = shift register bit 0, shifted right each bit time. DATA_BITS bits are sent, LSB first.
- PARITY: OUT = ^data for even parity, ~^data for odd parity, computed on the latched word.
- STOP: OUT=1 for STOP_BITS×CLKS_PER_BIT cycles.
- After the stop period the block returns to IDLE. DONE=1 and BUSY=0 in that first IDLE cycle. DONE is low in all other cycles.
- START or TX_IN changes while BUSY are ignored; they are not queued. TX_EN falling mid-frame does not abort; the frame completes.
- If START & TX_EN are high in the DONE cycle, the request is accepted and the next start bit begins on the following cycle. This gives exactly one mark cycle between frames.
- RST mid-frame: on the next cycle OUT=1, BUSY=0, DONE=0, state IDLE. The frame is truncated and no DONE is produced.
- Parameter checks: illegal parameter values stop elaboration ($error in an initial/generate check).

## Timing
- Acceptance at edge k: OUT=0 and BUSY=1 from cycle k+1.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, covering cycles k+1..k+F.
- DONE is high in cycle k+F+1.
- OUT is registered; no combinational path from any input to OUT.
- CLKS_PER_BIT=1 must give one bit per cycle with no bubbles.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - state enum tx_state_t (IDLE, START_BIT, DATA, PARITY, STOP);
  - the 9-bit maximum data width constant.
- One sub-module, uart_baud_tick: a counter parametrised by CLKS_PER_BIT with a clear input and a one-cycle tick output. It is shared with the future receiver.
- Top level holds the FSM, the shift register, the bit counter ($clog2(DATA_BITS+1) bits) and the stop-bit counter.

## Test plan
- 8N1, CLKS_PER_BIT=4, TX_IN=0xA5, START at edge 0 → OUT = 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, each held 4 cycles over cycles 1..40; BUSY high over 1..40; DONE only in cycle 41.
- 8E1 and 8O1, TX_IN=0x07 → parity bit is 1 for even and 0 for odd, in cycles 37..40; frame is 44 cycles.
- 5N2, CLKS_PER_BIT=4, TX_IN=0x1F → frame of 32 cycles with OUT=1 over cycles 25..32; DONE in cycle 33.
- START held high continuously, TX_IN=0x55 → back-to-back frames with exactly one OUT=1 cycle (the DONE cycle) between them; a START pulse injected mid-frame has no effect.
- RST asserted in the 3rd data bit → next cycle OUT=1, BUSY=0, and no DONE pulse. START with TX_EN=0 → OUT stays 1 and BUSY stays 0.
- CLKS_PER_BIT=1, 8N1, TX_IN=0x80 → OUT = 0, 0,0,0,0,0,0,0,1, 1 on consecutive cycles; DONE in cycle 11.
